lcd_nibble_writer: RTL

LCD_NIBBLE_WRITER -- requirements
Module: lcd_nibble_writer

---
 rtl/lcd_nibble_writer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: runs the HD44780-style 4-bit power-up init, then turns
// each accepted byte into two timed nibble writes (high nibble first).
//
// Handshake: in_valid/in_ready follow strict valid/ready rules -- a byte is
// taken on a rising edge where both are 1; in_ready is only 1 in IDLE after
// init has finished; the offer need not be held stable while in_ready is 0 and
// nothing is buffered.
//
// Every timed state lasts exactly its parameter's number of cycles; all
// timing parameters are expected to be >= 1.
module lcd_nibble_writer #(
  parameter int T_POWERUP = 750000,
  parameter int T_INIT1   = 205000,
  parameter int T_INIT2   = 5000,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000,
  parameter int T_NIB     = 50,
  parameter int T_SETUP   = 2,
  parameter int T_EHIGH   = 12,
  parameter int T_HOLD    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_w,
  output logic       lcd_e,
  output logic [3:0] data,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    PWR_WAIT, INIT_SETUP, INIT_E, INIT_HOLD, INIT_WAIT, IDLE,
    HI_SETUP, HI_E, HI_HOLD, NIB_GAP, LO_SETUP, LO_E, LO_HOLD, CMD_WAIT
  } state_t;

  // Counter sized for the longest wait so it can never wrap.
  localparam int M1    = (T_POWERUP > T_INIT1) ? T_POWERUP : T_INIT1;
  localparam int M2    = (M1 > T_INIT2) ? M1 : T_INIT2;
  localparam int M3    = (M2 > T_CMD) ? M2 : T_CMD;
  localparam int M4    = (M3 > T_CLEAR) ? M3 : T_CLEAR;
  localparam int M5    = (M4 > T_NIB) ? M4 : T_NIB;
  localparam int M6    = (M5 > T_SETUP) ? M5 : T_SETUP;
  localparam int M7    = (M6 > T_EHIGH) ? M6 : T_EHIGH;
  localparam int T_MAX = (M7 > T_HOLD) ? M7 : T_HOLD;
  localparam int CW    = $clog2(T_MAX + 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_limit;
  logic            w_last;
  logic [1:0]      r_init_idx;
  logic            r_rs;
  logic [7:0]      r_byte;
  logic            r_init_done;
  logic            w_is_clear;
  logic            w_accept;

  // Clear/home commands need the long settle time.
  assign w_is_clear = !r_rs && ((r_byte == 8'h01) || (r_byte == 8'h02) || (r_byte == 8'h03));
  assign w_accept   = (r_state == IDLE) && r_init_done && in_valid;

  // Duration of the current state and detection of its final cycle.
  always_comb begin
    w_limit = CW'(1);
    case (r_state)
      PWR_WAIT:                         w_limit = CW'(T_POWERUP);
      INIT_SETUP, HI_SETUP, LO_SETUP:   w_limit = CW'(T_SETUP);
      INIT_E, HI_E, LO_E:               w_limit = CW'(T_EHIGH);
      INIT_HOLD, HI_HOLD, LO_HOLD:      w_limit = CW'(T_HOLD);
      INIT_WAIT: begin
        case (r_init_idx)
          2'd0:    w_limit = CW'(T_INIT1);
          2'd1:    w_limit = CW'(T_INIT2);
          default: w_limit = CW'(T_CMD);
        endcase
      end
      NIB_GAP:                          w_limit = CW'(T_NIB);
      CMD_WAIT:                         w_limit = w_is_clear ? CW'(T_CLEAR) : CW'(T_CMD);
      default:                          w_limit = CW'(1);
    endcase
    w_last = (r_cnt == (w_limit - CW'(1)));
  end

  // Next-state logic and strobe/data outputs decoded from the state.
  always_comb begin
    w_next = r_state;
    lcd_e  = 1'b0;
    lcd_rs = 1'b0;
    data   = 4'h0;
    case (r_state)
      PWR_WAIT:   if (w_last) w_next = INIT_SETUP;
      INIT_SETUP: if (w_last) w_next = INIT_E;
      INIT_E:     if (w_last) w_next = INIT_HOLD;
      INIT_HOLD:  if (w_last) w_next = INIT_WAIT;
      INIT_WAIT:  if (w_last) w_next = (r_init_idx == 2'd3) ? IDLE : INIT_SETUP;
      IDLE:       if (w_accept) w_next = HI_SETUP;
      HI_SETUP:   if (w_last) w_next = HI_E;
      HI_E:       if (w_last) w_next = HI_HOLD;
      HI_HOLD:    if (w_last) w_next = NIB_GAP;
      NIB_GAP:    if (w_last) w_next = LO_SETUP;
      LO_SETUP:   if (w_last) w_next = LO_E;
      LO_E:       if (w_last) w_next = LO_HOLD;
      LO_HOLD:    if (w_last) w_next = CMD_WAIT;
      CMD_WAIT:   if (w_last) w_next = IDLE;
      default:    w_next = PWR_WAIT;
    endcase

    case (r_state)
      INIT_SETUP, INIT_E, INIT_HOLD: data = (r_init_idx == 2'd3) ? 4'h2 : 4'h3;
      HI_SETUP, HI_E, HI_HOLD, NIB_GAP: begin
        data   = r_byte[7:4];
        lcd_rs = r_rs;
      end
      LO_SETUP, LO_E, LO_HOLD: begin
        data   = r_byte[3:0];
        lcd_rs = r_rs;
      end
      default: data = 4'h0;
    endcase

    lcd_e = (r_state == INIT_E) || (r_state == HI_E) || (r_state == LO_E);
  end

  assign in_ready  = (r_state == IDLE) && r_init_done;
  assign init_done = r_init_done;
  assign lcd_w     = 1'b0;
  assign dbg_state = r_state;

  // State, wait counter, init progress and latched byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= PWR_WAIT;
      r_cnt       <= '0;
      r_init_idx  <= 2'd0;
      r_rs        <= 1'b0;
      r_byte      <= 8'h00;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == IDLE) || w_last) r_cnt <= '0;
      else                             r_cnt <= r_cnt + CW'(1);
      if ((r_state == INIT_WAIT) && w_last) begin
        r_init_idx <= r_init_idx + 2'd1;
        if (r_init_idx == 2'd3) r_init_done <= 1'b1;
      end
      if (w_accept) begin
        r_rs   <= in_rs;
        r_byte <= in_byte;
      end
    end
  end

endmodule
